// File: rtl/ififo_pkg.sv
// Instruction FIFO entry type shared by the FIFO and its neighbours.
package ififo_pkg;

   // One fetched instruction together with its branch prediction
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        is_cond_br;
      logic        br_dir_pred;
      logic [31:0] br_target_pred;
   } ififo_entry_t;

endpackage

// File: rtl/ififo.sv
// Instruction FIFO between fetch and dispatch.
// Circular buffer with wrap-bit pointers, one-cycle enqueue-to-output latency.
// Optional feature: define IFIFO_BYPASS_EN to let an entry offered to an
// empty FIFO reach dispatch in the same cycle.
module ififo
   import ififo_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_ififo_valid,
   output logic                     fetch_ififo_ready,
   input  ififo_entry_t             fetch_ififo_data,
   output logic                     ififo_dispatch_valid,
   input  logic                     ififo_dispatch_ready,
   output ififo_entry_t             ififo_dispatch_data,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [AW:0]   head;
   logic [AW:0]   tail;
   ififo_entry_t  mem [DEPTH];

   logic full;
   logic empty;
   logic enq;
   logic deq;
   logic wr;
   logic rd;

   assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
   assign empty = (head == tail);

   // Reset forces the idle handshake so outputs are clean even before pointers settle
   assign fetch_ififo_ready = rst | (!full & !flush);

`ifdef IFIFO_BYPASS_EN
   logic bypass;
   assign bypass               = empty & fetch_ififo_valid & !flush & !rst;
   assign ififo_dispatch_valid = !rst & !flush & (!empty | bypass);
   assign ififo_dispatch_data  = bypass ? fetch_ififo_data : mem[head[AW-1:0]];
`else
   assign ififo_dispatch_valid = !rst & !flush & !empty;
   assign ififo_dispatch_data  = mem[head[AW-1:0]];
`endif

   assign enq = fetch_ififo_valid & fetch_ififo_ready & !rst;
   assign deq = ififo_dispatch_valid & ififo_dispatch_ready;

`ifdef IFIFO_BYPASS_EN
   // A bypassed entry that dispatch takes right away never lands in storage
   assign wr = enq & !(bypass & ififo_dispatch_ready);
`else
   assign wr = enq;
`endif
   // Only a stored entry moves the head; a bypassed one leaves it in place
   assign rd = deq & !empty;

   assign count = rst ? '0 : (tail - head);

   // Pointer update: reset and flush both empty the buffer and win over traffic
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (wr) tail <= tail + {{AW{1'b0}}, 1'b1};
         if (rd) head <= head + {{AW{1'b0}}, 1'b1};
      end
   end

   // Entry storage, written at tail; contents survive reset untouched
   always_ff @(posedge clk) begin
      if (wr) mem[tail[AW-1:0]] <= fetch_ififo_data;
   end

endmodule

// File: doc/ififo.md
IFIFO -- requirements
Module: ififo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of entries; a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 SHALL have port fetch_ififo_valid, input, 1 bit, fetch offers an entry.
REQ-005 SHALL have port fetch_ififo_ready, output, 1 bit, the FIFO accepts an entry this cycle.
REQ-006 SHALL have port fetch_ififo_data, input, ififo_entry_t (98 b), the entry fields:
- instr (32)
- pc (32)
- is_cond_br (1)
- br_dir_pred (1)
- br_target_pred (32)
REQ-007 SHALL have port ififo_dispatch_valid, output, 1 bit, the head entry is offered to dispatch.
REQ-008 SHALL have port ififo_dispatch_ready, input, 1 bit, dispatch consumes the head this cycle; may depend combinationally on ififo_dispatch_valid/data.
REQ-009 SHALL have port ififo_dispatch_data, output, ififo_entry_t, the head entry.
REQ-010 SHALL have port flush, input, 1 bit, fetch redirect; driven by fetch_redirect_pc_valid.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits, current occupancy.

Function
REQ-012 SHALL be a circular buffer:
- head and tail pointers, each $clog2(DEPTH) bits plus a wrap bit;
- full = (indices equal and wrap bits differ);
- empty = (pointers equal).
REQ-013 SHALL define enq = fetch_ififo_valid & fetch_ififo_ready; on enq, write the entry at tail and advance tail by 1 modulo DEPTH, toggling the wrap bit on wrap.
REQ-014 SHALL define deq = ififo_dispatch_valid & ififo_dispatch_ready; on deq, advance head likewise.
REQ-015 SHALL drive fetch_ififo_ready = !full & !flush; no enqueue while full, even with a simultaneous deq.
REQ-016 SHALL drive ififo_dispatch_valid = !empty & !flush.
REQ-017 SHALL drive ififo_dispatch_data combinationally from the entry at head.
REQ-018 SHALL give one-cycle latency: an entry enqueued in cycle N is first visible at the output in cycle N+1.
REQ-019 SHALL on simultaneous enq and deq update both pointers and leave count unchanged; this is legal when the FIFO is neither empty nor full.
REQ-020 SHALL maintain count = tail - head (including wrap bit), ranging 0..DEPTH.
REQ-021 SHALL on flush:
- take no enq and no deq in the flush cycle;
- set head = tail = 0 and count = 0 at the next edge;
- flush has priority over enq and deq.
REQ-022 SHALL preserve FIFO order exactly; no entry is dropped or duplicated except by flush or rst.

Reset
REQ-023 SHALL, when rst is high at a clock edge, set head = tail = 0 and count = 0; storage contents need not be cleared.
REQ-024 SHALL hold these output values during and in the cycle after reset:
- fetch_ififo_ready = 1
- ififo_dispatch_valid = 0
- count = 0
REQ-025 SHALL let rst asserted mid-operation override any same-cycle enq, deq or flush.

Configuration
REQ-026 SHALL, with macro IFIFO_BYPASS_EN defined, add an empty bypass: when empty & fetch_ififo_valid & !flush:
- ififo_dispatch_valid = 1 and ififo_dispatch_data = fetch_ififo_data in the same cycle;
- if ififo_dispatch_ready = 1, the entry is consumed and not written, so pointers are unchanged;
- otherwise the entry is enqueued normally.
REQ-027 SHALL, without IFIFO_BYPASS_EN, have no combinational path from fetch_ififo_* to ififo_dispatch_*; minimum latency is 1 cycle per REQ-018.

Verification
REQ-028 SHALL cover fill and drain: DEPTH=8, dispatch_ready=0, enqueue 8 entries with pc 0x0,0x4,...,0x1C -> ready=0 after the 8th and count=8; then dispatch_ready=1 -> pcs 0x0..0x1C emerge in order over 8 cycles, count=0, valid=0.
REQ-029 SHALL cover simultaneous enq/deq: with 4 entries, enqueue and dequeue every cycle for 20 cycles -> count stays 4; pointers wrap at least twice; order is preserved.
REQ-030 SHALL cover flush: with 5 entries and fetch_valid=1, assert flush for one cycle -> in that cycle dispatch_valid=0 and fetch_ready=0; next cycle count=0 and valid=0; the entry offered during flush is absent.
REQ-031 SHALL cover full boundary: when full, assert deq and fetch_valid together -> the head is dequeued, no enqueue occurs, and count becomes 7.
REQ-032 SHALL cover reset mid-operation: 3 entries, then rst=1 together with enq -> next cycle count=0, valid=0, ready=1.
REQ-033 SHALL cover bypass: with IFIFO_BYPASS_EN, empty FIFO, fetch offers pc=0x100 with dispatch_ready=1 -> same cycle valid=1 and data.pc=0x100; count stays 0; without the macro, valid rises one cycle later.
